// File: rtl/uart_tx_fifo_if.sv
// Byte-write / serial-line bundle of the UART transmitter.
// The master side is the user logic and the slave side is uart_tx_fifo.
interface uart_tx_fifo_if #(
  parameter int PAYLOAD_BITS = 8
);
  logic [PAYLOAD_BITS-1:0] uart_tx_data;
  logic                    uart_tx_en;
  logic                    uart_tx_ready;
  logic                    uart_tx_overflow;
  logic                    uart_tx_busy;
  logic                    uart_txd;

  modport master (
    output uart_tx_data, uart_tx_en,
    input  uart_tx_ready, uart_tx_overflow, uart_tx_busy, uart_txd
  );

  modport slave (
    input  uart_tx_data, uart_tx_en,
    output uart_tx_ready, uart_tx_overflow, uart_tx_busy, uart_txd
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter: small byte FIFO feeding an 8N1 serialiser.
// The serialiser sends 8E1 frames instead when UART_TX_PARITY_EN is defined.
module uart_tx_fifo #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BIT_RATE     = 9_600,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_fifo_if.slave  bus
);

  localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int CNT_W          = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam int AW             = $clog2(FIFO_DEPTH);
  localparam int IDX_W          = $clog2(PAYLOAD_BITS) + 1;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(PAYLOAD_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic [PAYLOAD_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]             r_wr_ptr;
  logic [AW:0]             r_rd_ptr;
  state_t                  r_state;
  logic [CNT_W-1:0]        r_baud;
  logic [IDX_W-1:0]        r_bit_idx;
  logic [PAYLOAD_BITS-1:0] r_shift;
  logic                    r_txd;
  logic                    r_ready;
  logic                    r_overflow;
  logic                    r_busy;
`ifdef UART_TX_PARITY_EN
  logic                    r_parity;
`endif

  logic                    w_full;
  logic                    w_empty;
  logic                    w_wr;
  logic                    w_pop;
  logic                    w_baud_end;
  logic [PAYLOAD_BITS-1:0] w_head;

  // Equal slot index with differing wrap bits means the write side lapped the read side.
  assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_wr       = bus.uart_tx_en & ~w_full;
  assign w_pop      = (r_state == S_IDLE) & ~w_empty;
  assign w_baud_end = (r_baud == BAUD_LAST);
  assign w_head     = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr[AW-1:0]] <= bus.uart_tx_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_state    <= S_IDLE;
      r_baud     <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_txd      <= 1'b1;
      r_ready    <= 1'b1;
      r_overflow <= 1'b0;
      r_busy     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end

      // A pop in this same cycle does not make room for a write attempted while full.
      r_overflow <= bus.uart_tx_en & w_full;
      r_ready    <= ~w_full;
      r_busy     <= (r_state != S_IDLE) | ~w_empty;

      // The line follows the state one cycle later, so every bit lasts exactly one baud period.
      unique case (r_state)
        S_IDLE:   r_txd <= 1'b1;
        S_START:  r_txd <= 1'b0;
        S_DATA:   r_txd <= r_shift[0];
`ifdef UART_TX_PARITY_EN
        S_PARITY: r_txd <= r_parity;
`endif
        S_STOP:   r_txd <= 1'b1;
        default:  r_txd <= 1'b1;
      endcase

      unique case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_shift   <= w_head;
`ifdef UART_TX_PARITY_EN
            r_parity  <= ^w_head;
`endif
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_state   <= S_START;
          end
        end
        S_START: begin
          if (w_baud_end) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_state   <= S_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_DATA: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_shift <= {1'b0, r_shift[PAYLOAD_BITS-1:1]};
            if (r_bit_idx == DATA_LAST) begin
              r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              r_state   <= S_PARITY;
`else
              r_state   <= S_STOP;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_state <= S_STOP;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (r_bit_idx == STOP_LAST) begin
              r_bit_idx <= '0;
              r_state   <= S_IDLE;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.uart_txd         = r_txd;
  assign bus.uart_tx_ready    = r_ready;
  assign bus.uart_tx_overflow = r_overflow;
  assign bus.uart_tx_busy     = r_busy;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at 10 clocks per bit; frames are checked cycle by cycle.
// Build with UART_TX_PARITY_EN defined to expect 8E1 frames.
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.PAYLOAD_BITS(8)) bus ();

  uart_tx_fifo #(
    .CLK_HZ      (1_000_000),
    .BIT_RATE    (100_000),
    .PAYLOAD_BITS(8),
    .STOP_BITS   (1),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] b3 [4] = '{8'hA3, 8'h00, 8'hFF, 8'h5C};
  logic [7:0] b4 [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    bus.uart_tx_data = b;
    bus.uart_tx_en   = 1'b1;
    tick();
    bus.uart_tx_en   = 1'b0;
  endtask

  task automatic wait_start(input int budget);
    for (int c = 0; c < budget && bus.uart_txd !== 1'b0; c++) tick();
    chk("start_seen", bus.uart_txd, 0);
  endtask

  // Called on the first cycle of the start bit; returns on the cycle after the last stop cycle.
  task automatic check_frame(input logic [7:0] b);
    logic [11:0] bits;
    logic [1:0]  g;
    int          n;
    bits    = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = b[i];
    n = 9;
`ifdef UART_TX_PARITY_EN
    bits[n] = ^b;
    n++;
`endif
    bits[n] = 1'b1;
    n++;
    for (int k = 0; k < n; k++) begin
      g = {1'b0, bus.uart_txd};
      for (int c = 0; c < 10; c++) begin
        if (bus.uart_txd !== g[0]) g = 2'b10;
        tick();
      end
      chk($sformatf("f%02h_bit%0d", b, k), 32'(g), 32'(bits[k]));
    end
    $display("frame %02h: %0d bit times checked", b, n);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic all_txd, all_rdy, any_busy, any_ovf;
    bus.uart_tx_data = '0;
    bus.uart_tx_en   = 1'b0;

    // 1: reset values, then 100 idle cycles
    tick(); tick(); tick();
    chk("rst_txd", bus.uart_txd, 1);
    chk("rst_ready", bus.uart_tx_ready, 1);
    chk("rst_busy", bus.uart_tx_busy, 0);
    chk("rst_ovf", bus.uart_tx_overflow, 0);
    rst = 1'b1;
    all_txd = 1'b1; all_rdy = 1'b1; any_busy = 1'b0; any_ovf = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick();
      all_txd  &= bus.uart_txd;
      all_rdy  &= bus.uart_tx_ready;
      any_busy |= bus.uart_tx_busy;
      any_ovf  |= bus.uart_tx_overflow;
    end
    chk("idle_txd", all_txd, 1);
    chk("idle_ready", all_rdy, 1);
    chk("idle_busy", any_busy, 0);
    chk("idle_ovf", any_ovf, 0);

    // 2: single byte, two-cycle latency to start bit
    write_byte(8'h55);
    tick();
    chk("lat_n1", bus.uart_txd, 1);
    tick();
    chk("lat_n2", bus.uart_txd, 0);
    chk("busy_frame", bus.uart_tx_busy, 1);
    check_frame(8'h55);
    chk("after_idle", bus.uart_txd, 1);
    tick(); tick();
    chk("busy_drop", bus.uart_tx_busy, 0);

    // 3: four back-to-back bytes, exactly one idle cycle between frames
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          bus.uart_tx_data = b3[i];
          bus.uart_tx_en   = 1'b1;
          tick();
        end
        bus.uart_tx_en = 1'b0;
      end
      begin
        wait_start(20);
        for (int i = 0; i < 4; i++) begin
          check_frame(b3[i]);
          chk("gap_idle", bus.uart_txd, 1);
          tick();
          if (i < 3) chk("gap_next", bus.uart_txd, 0);
        end
      end
    join
    for (int c = 0; c < 5; c++) tick();

    // 4: six writes; one frame in flight plus four queued, sixth dropped
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          bus.uart_tx_data = b4[i];
          bus.uart_tx_en   = 1'b1;
          tick();
          if (i == 4) chk("ovf_pre", bus.uart_tx_overflow, 0);
        end
        bus.uart_tx_en = 1'b0;
        chk("ovf_pulse", bus.uart_tx_overflow, 1);
        chk("ready_full", bus.uart_tx_ready, 0);
        tick();
        chk("ovf_clear", bus.uart_tx_overflow, 0);
      end
      begin
        logic low_seen;
        wait_start(20);
        for (int i = 0; i < 5; i++) begin
          check_frame(b4[i]);
          chk("gap_idle4", bus.uart_txd, 1);
          tick();
          if (i < 4) chk("gap_next4", bus.uart_txd, 0);
        end
        low_seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
          if (bus.uart_txd === 1'b0) low_seen = 1'b1;
          tick();
        end
        chk("no_6th", low_seen, 0);
        chk("ready_back", bus.uart_tx_ready, 1);
      end
    join

    // 5: reset in the middle of a data bit, with a second byte queued
    write_byte(8'h81);
    write_byte(8'h99);
    wait_start(10);
    for (int c = 0; c < 15; c++) tick();
    #2 rst = 1'b0;
    #1;
    chk("abort_txd", bus.uart_txd, 1);
    chk("abort_busy", bus.uart_tx_busy, 0);
    chk("abort_ready", bus.uart_tx_ready, 1);
    tick(); tick();
    rst = 1'b1;
    all_txd = 1'b1; any_busy = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick();
      all_txd  &= bus.uart_txd;
      any_busy |= bus.uart_tx_busy;
    end
    chk("flush_txd", all_txd, 1);
    chk("flush_busy", any_busy, 0);
    write_byte(8'h42);
    tick(); tick();
    chk("post_rst_start", bus.uart_txd, 0);
    check_frame(8'h42);

    // 6: odd and even parity payloads
    tick(); tick();
    write_byte(8'h07);
    tick(); tick();
    chk("p07_start", bus.uart_txd, 0);
    check_frame(8'h07);
    tick(); tick();
    write_byte(8'h03);
    tick(); tick();
    chk("p03_start", bus.uart_txd, 0);
    check_frame(8'h03);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
